rx_timer: RTL and testbench

USB receive-side bit-timing recovery block: the receive-path counterpart of the transmit timer. It locks bit phase to the first line transition after reception is enabled and resynchronises on every later transition. It produces a mid-bit sample strobe, a stuffed-bit-aware shift enable for the RX shift register, and a byte-received pulse after every 8 data bits. It sits between the RX edge detector / bit unstuffer and the RX shift register / RX control FSM.

---
 rtl/rx_timer.sv | 117 +++++++++++
 tb/tb_rx_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_timer.sv
`default_nettype none
// ============================================================================
// Module  : rx_timer
// Purpose : USB receive bit-timing recovery: mid-bit sample strobe, stuffing-
//           aware shift enable and byte-received pulse. Build option
//           RX_TIMER_RESYNC_EN re-aligns the bit phase on every line edge.
// Revision: 1.0 - initial release
// ============================================================================
module rx_timer #(
    parameter int BIT_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_timer,
    input  logic d_edge,
    input  logic bit_stuffed,
    output logic sample_strobe,
    output logic shift_enable,
    output logic byte_received
);

    localparam int PW = $clog2(BIT_PERIOD);
    localparam logic [PW-1:0] c_sample_phase = PW'(BIT_PERIOD / 2);
    localparam logic [PW-1:0] c_last_phase   = PW'(BIT_PERIOD - 1);
    localparam logic [PW-1:0] c_one          = PW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC_WAIT = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_phase, w_phase_next;
    logic [2:0]      r_bit,   w_bit_next;
    logic            r_byte,  w_byte_next;
    logic            w_strobe;
    logic            w_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_byte  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_bit   <= w_bit_next;
            r_byte  <= w_byte_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_bit_next   = r_bit;
        w_byte_next  = 1'b0;
        w_strobe     = 1'b0;
        w_shift      = 1'b0;

        case (r_state)
            IDLE: begin
                w_phase_next = '0;
                w_bit_next   = '0;
                if (enable_timer) begin
                    w_state_next = SYNC_WAIT;
                end
            end
            SYNC_WAIT: begin
                // The locking edge itself is phase 0 of the first bit.
                w_phase_next = '0;
                if (d_edge) begin
                    w_state_next = RUN;
                    w_phase_next = c_one;
                end
            end
            RUN: begin
`ifdef RX_TIMER_RESYNC_EN
                // An edge on the sample phase wins: the bit is re-timed, not sampled.
                w_strobe = (r_phase == c_sample_phase) && !d_edge;
                if (d_edge) begin
                    w_phase_next = c_one;
                end else begin
                    w_phase_next = (r_phase == c_last_phase) ? '0 : r_phase + c_one;
                end
`else
                w_strobe     = (r_phase == c_sample_phase);
                w_phase_next = (r_phase == c_last_phase) ? '0 : r_phase + c_one;
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Dropping enable aborts any partial byte in the same cycle.
        if (!enable_timer) begin
            w_state_next = IDLE;
            w_phase_next = '0;
            w_bit_next   = '0;
            w_strobe     = 1'b0;
        end

        w_shift = w_strobe && !bit_stuffed;
        if (w_shift) begin
            w_bit_next  = r_bit + 3'd1;
            w_byte_next = (r_bit == 3'd7);
        end
    end

    assign sample_strobe = w_strobe;
    assign shift_enable  = w_shift;
    assign byte_received = r_byte && enable_timer;

endmodule
`default_nettype wire

// File: tb/tb_rx_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_timer
// Purpose : Scoreboard bench for rx_timer: expected strobe/shift/byte cycles
//           are queued as the line is driven and matched as outputs appear.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rx_timer;

    logic clk          = 1'b0;
    logic rst          = 1'b1;
    logic enable_timer = 1'b0;
    logic d_edge       = 1'b0;
    logic bit_stuffed  = 1'b0;
    logic sample_strobe;
    logic shift_enable;
    logic byte_received;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    int exp_strobe[$];
    int exp_shift[$];
    int exp_byte[$];

    rx_timer #(.BIT_PERIOD(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_timer  (enable_timer),
        .d_edge        (d_edge),
        .bit_stuffed   (bit_stuffed),
        .sample_strobe (sample_strobe),
        .shift_enable  (shift_enable),
        .byte_received (byte_received)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Every output pulse must match the head of its queue.
    always @(negedge clk) begin
        if (sample_strobe) begin
            if (exp_strobe.size() == 0) check("strobe_unexpected", cyc, -1);
            else                        check("strobe_cycle", cyc, exp_strobe.pop_front());
        end
        if (shift_enable) begin
            if (exp_shift.size() == 0) check("shift_unexpected", cyc, -1);
            else                       check("shift_cycle", cyc, exp_shift.pop_front());
        end
        if (byte_received) begin
            if (exp_byte.size() == 0) check("byte_unexpected", cyc, -1);
            else                      check("byte_cycle", cyc, exp_byte.pop_front());
        end
    end

    task automatic restart;
        enable_timer = 1'b0;
        d_edge       = 1'b0;
        bit_stuffed  = 1'b0;
        repeat (2) tick();
        enable_timer = 1'b1;
        repeat (2) tick();
    endtask

    // Plays nbits bits starting with the sync edge. Bit k starts with an edge at
    // e[k]; bit drift_bit+1 starts drift_ph cycles after bit drift_bit.
    // mode 1 drops enable at relative cycle cut, mode 2 pulses rst there.
    task automatic send_bits(input int nbits, input int stuff_k, input int drift_bit,
                             input int drift_ph, input int mode, input int cut);
        int  e[16];
        int  s[16];
        bit  lost;
        int  t0;
        int  last;
        int  nshift;
        e[0] = 0;
        for (int k = 1; k < nbits; k++)
            e[k] = (k == drift_bit + 1) ? e[k-1] + drift_ph : e[k-1] + 8;
        for (int k = 0; k < nbits; k++) begin
`ifdef RX_TIMER_RESYNC_EN
            s[k] = e[k] + 4;
`else
            s[k] = 4 + 8 * k;
`endif
        end
        tick();
        t0     = cyc;
        nshift = 0;
        for (int k = 0; k < nbits; k++) begin
            lost = 1'b0;
`ifdef RX_TIMER_RESYNC_EN
            for (int j = 0; j < nbits; j++)
                if (e[j] == s[k]) lost = 1'b1;
`endif
            if (!lost && (cut < 0 || s[k] < cut)) begin
                exp_strobe.push_back(t0 + s[k]);
                if (k != stuff_k) begin
                    exp_shift.push_back(t0 + s[k]);
                    nshift++;
                    if (nshift % 8 == 0 && (cut < 0 || s[k] + 1 < cut))
                        exp_byte.push_back(t0 + s[k] + 1);
                end
            end
        end
        last = s[nbits-1] + 3;
        for (int rel = 0; rel <= last; rel++) begin
            if (rel > 0) tick();
            d_edge      = 1'b0;
            bit_stuffed = 1'b0;
            for (int k = 0; k < nbits; k++)
                if (e[k] == rel) d_edge = 1'b1;
            if (stuff_k >= 0 && rel == s[stuff_k]) bit_stuffed = 1'b1;
            if (rel == cut) begin
                d_edge      = 1'b0;
                bit_stuffed = 1'b0;
                if (mode == 1) begin
                    enable_timer = 1'b0;
                end else begin
                    #1;
                    check("pre_rst_strobe", int'(sample_strobe), 1);
                    rst = 1'b1;
                    #1;
                    check("async_rst_strobe", int'(sample_strobe), 0);
                    check("async_rst_shift",  int'(shift_enable), 0);
                    check("async_rst_byte",   int'(byte_received), 0);
                    #1;
                    rst = 1'b0;
                end
                break;
            end
        end
        d_edge      = 1'b0;
        bit_stuffed = 1'b0;
        repeat (3) tick();
        check("strobe_missing", exp_strobe.size(), 0);
        check("shift_missing",  exp_shift.size(), 0);
        check("byte_missing",   exp_byte.size(), 0);
        exp_strobe.delete();
        exp_shift.delete();
        exp_byte.delete();
    endtask

    initial begin
        rst          = 1'b1;
        enable_timer = 1'b1;
        d_edge       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobe", int'(sample_strobe), 0);
        check("reset_shift",  int'(shift_enable), 0);
        check("reset_byte",   int'(byte_received), 0);
        enable_timer = 1'b0;
        d_edge       = 1'b0;
        rst          = 1'b0;
        tick();

        // Enabled with no line activity: must stay silent in SYNC_WAIT.
        enable_timer = 1'b1;
        repeat (50) tick();

        send_bits(8, -1, -1, 0, 0, -1);   // plain byte, edges at bit boundaries
        restart();
        send_bits(8, -1, 3, 6, 0, -1);    // drift: edge at phase 6 of bit 3
        restart();
        send_bits(9, 6, -1, 0, 0, -1);    // stuffed 7th bit
        restart();
        send_bits(9, -1, 2, 4, 0, -1);    // edge coincident with a sample phase
        restart();
        send_bits(8, -1, -1, 0, 1, 37);   // enable drops right after 5th shift
        restart();
        send_bits(8, -1, -1, 0, 0, -1);   // fresh byte needs a full 8 shifts
        restart();
        send_bits(8, -1, -1, 0, 1, 61);   // enable drops on the pending byte pulse
        restart();
        send_bits(8, -1, -1, 0, 1, 20);   // enable drops in a strobe cycle
        restart();
        send_bits(8, -1, -1, 0, 2, 28);   // async reset mid-byte
        restart();
        send_bits(8, -1, -1, 0, 0, -1);
        restart();
        send_bits(16, -1, -1, 0, 0, -1);  // back-to-back bytes

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
